mesh_router: RTL and testbench

// Unbuffered dimension-ordered (X-then-Y) router for one tile of a 2-D mesh NoC.
// It takes one packet per input port (P, W, E, N, S) and routes it to an output port.
// The route is chosen by comparing the packet's destination coordinates with the tile's own.

---
 rtl/mesh_router.sv | 115 +++++++++++
 tb/tb_mesh_router.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mesh_router.sv
// Unbuffered X-then-Y dimension-ordered router for one 2-D mesh tile.
// Combinational input-to-output path; the only state is one round-robin pointer per output.
module mesh_router #(
  parameter int dims_p         = 2,
  parameter int width_p        = 32,
  parameter int x_cord_width_p = 4,
  parameter int y_cord_width_p = 4
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [(2*dims_p+1)*width_p-1:0]    data_i,
  input  logic [2*dims_p:0]                  v_i,
  output logic [2*dims_p:0]                  yumi_o,
  output logic [(2*dims_p+1)*width_p-1:0]    data_o,
  output logic [2*dims_p:0]                  v_o,
  input  logic [2*dims_p:0]                  ready_and_i,
  input  logic [x_cord_width_p-1:0]          my_x_i,
  input  logic [y_cord_width_p-1:0]          my_y_i
);

  localparam int dirs_lp  = 2*dims_p + 1;
  localparam int ptr_w_lp = $clog2(dirs_lp);

  typedef logic [ptr_w_lp-1:0] idx_t;

  localparam idx_t dir_p_lp = idx_t'(0);
  localparam idx_t dir_w_lp = idx_t'(1);
  localparam idx_t dir_e_lp = idx_t'(2);
  localparam idx_t dir_n_lp = idx_t'(3);
  localparam idx_t dir_s_lp = idx_t'(4);

  // Handshake: inputs are valid/yumi (yumi_o pulses in the cycle the packet leaves the
  // upstream FIFO); outputs are valid/ready-and (v_o never waits on ready_and_i, and a
  // transfer on an output happens exactly when v_o & ready_and_i).

  idx_t                        route    [dirs_lp];
  logic [dirs_lp-1:0]          req      [dirs_lp];
  logic [dirs_lp-1:0]          gnt_v;
  logic [dirs_lp-1:0][ptr_w_lp-1:0] gnt_idx;
  logic [dirs_lp-1:0][ptr_w_lp-1:0] ptr_r;

  function automatic idx_t route_f(input logic [x_cord_width_p-1:0] dx,
                                   input logic [y_cord_width_p-1:0] dy,
                                   input logic [x_cord_width_p-1:0] mx,
                                   input logic [y_cord_width_p-1:0] my);
    idx_t r;
    r = dir_p_lp;
    if (dx < mx)      r = dir_w_lp;
    else if (dx > mx) r = dir_e_lp;
    else if (dims_p > 1) begin
      if (dy < my)      r = dir_n_lp;
      else if (dy > my) r = dir_s_lp;
    end
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < dirs_lp; i++) begin
      route[i] = route_f(data_i[i*width_p +: x_cord_width_p],
                         data_i[i*width_p + x_cord_width_p +: y_cord_width_p],
                         my_x_i, my_y_i);
    end
    for (int o = 0; o < dirs_lp; o++) begin
      for (int i = 0; i < dirs_lp; i++) begin
        req[o][i] = v_i[i] && (route[i] == idx_t'(o));
      end
    end
  end

  // Search begins at the pointer, which holds one past the last input that transferred.
  always_comb begin
    int cand;
    cand    = 0;
    gnt_v   = '0;
    gnt_idx = '0;
    for (int o = 0; o < dirs_lp; o++) begin
      for (int k = 0; k < dirs_lp; k++) begin
        cand = (int'(ptr_r[o]) + k) % dirs_lp;
        if (!gnt_v[o] && req[o][cand]) begin
          gnt_v[o]   = 1'b1;
          gnt_idx[o] = idx_t'(cand);
        end
      end
    end
  end

  always_comb begin
    v_o    = '0;
    yumi_o = '0;
    data_o = '0;
    if (!reset_i) begin
      for (int o = 0; o < dirs_lp; o++) begin
        v_o[o] = |req[o];
        if (gnt_v[o]) begin
          data_o[o*width_p +: width_p] = data_i[int'(gnt_idx[o])*width_p +: width_p];
          if (ready_and_i[o]) yumi_o[gnt_idx[o]] = 1'b1;
        end
      end
    end
  end

  // Pointers only move on an actual transfer, so a stalled grant stays put.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ptr_r <= '0;
    end else begin
      for (int o = 0; o < dirs_lp; o++) begin
        if (gnt_v[o] && ready_and_i[o]) begin
          ptr_r[o] <= idx_t'((int'(gnt_idx[o]) + 1) % dirs_lp);
        end
      end
    end
  end

endmodule

// File: tb/tb_mesh_router.sv
// Directed and randomized bench for mesh_router (2-D, 2-bit coordinates, tile at (1,1)).
// A spec-level model (route by coordinate compare, last-granted round robin) predicts every cycle.
module tb_mesh_router;

  localparam int W = 8;
  localparam int D = 5;
  localparam int MY_X = 1;
  localparam int MY_Y = 1;

  logic           clk_i = 1'b0;
  logic           reset_i;
  logic [D*W-1:0] data_i;
  logic [D-1:0]   v_i;
  logic [D-1:0]   yumi_o;
  logic [D*W-1:0] data_o;
  logic [D-1:0]   v_o;
  logic [D-1:0]   ready_and_i;
  logic [1:0]     my_x_i;
  logic [1:0]     my_y_i;

  mesh_router #(
    .dims_p(2), .width_p(W), .x_cord_width_p(2), .y_cord_width_p(2)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .data_i(data_i), .v_i(v_i), .yumi_o(yumi_o),
    .data_o(data_o), .v_o(v_o), .ready_and_i(ready_and_i), .my_x_i(my_x_i), .my_y_i(my_y_i)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  int n_cmp  = 0;
  int n_fail = 0;
  int last_g [D];
  int m_win  [D];
  logic [49:0] exp_q [$];

  // reference model
  function automatic int route_m(input logic [7:0] pkt);
    int dx, dy;
    dx = int'(pkt[1:0]);
    dy = int'(pkt[3:2]);
    if (dx != MY_X) return (dx < MY_X) ? 1 : 2;
    if (dy != MY_Y) return (dy < MY_Y) ? 3 : 4;
    return 0;
  endfunction

  function automatic void model_eval(input logic rst, input logic [4:0] v,
                                     input logic [39:0] d, input logic [4:0] rdy);
    logic [4:0]  ev;
    logic [4:0]  ey;
    logic [39:0] ed;
    int c;
    ev = '0; ey = '0; ed = '0;
    for (int o = 0; o < D; o++) begin
      m_win[o] = -1;
      if (!rst) begin
        for (int off = 1; off <= D; off++) begin
          c = (last_g[o] + off) % D;
          if (m_win[o] < 0 && v[c] && route_m(d[c*W +: W]) == o) m_win[o] = c;
        end
      end
      if (m_win[o] >= 0) begin
        ev[o] = 1'b1;
        ed[o*W +: W] = d[m_win[o]*W +: W];
        if (rdy[o]) ey[m_win[o]] = 1'b1;
      end
    end
    exp_q.push_back({ev, ey, ed});
  endfunction

  function automatic void model_commit(input logic rst, input logic [4:0] rdy);
    for (int o = 0; o < D; o++) begin
      if (rst) last_g[o] = D - 1;
      else if (m_win[o] >= 0 && rdy[o]) last_g[o] = m_win[o];
    end
  endfunction

  // scoreboard check
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  function automatic logic [7:0] pk(input logic [3:0] pay, input int x, input int y);
    return {pay, 2'(y), 2'(x)};
  endfunction

  function automatic logic [39:0] pack5(input logic [7:0] p0, input logic [7:0] p1,
                                        input logic [7:0] p2, input logic [7:0] p3,
                                        input logic [7:0] p4);
    return {p4, p3, p2, p1, p0};
  endfunction

  task automatic step(input string tag, input logic rst, input logic [4:0] v,
                      input logic [39:0] d, input logic [4:0] rdy);
    logic [49:0] e;
    @(negedge clk_i);
    reset_i = rst; v_i = v; data_i = d; ready_and_i = rdy;
    #1;
    model_eval(rst, v, d, rdy);
    e = exp_q.pop_front();
    check({tag, ".v_o"},    64'(v_o),    64'(e[49:45]));
    check({tag, ".yumi_o"}, 64'(yumi_o), 64'(e[44:40]));
    check({tag, ".data_o"}, 64'(data_o), 64'(e[39:0]));
    model_commit(rst, rdy);
  endtask

  logic [39:0] d;
  logic [7:0]  pa, pb, pc;

  initial begin
    for (int o = 0; o < D; o++) last_g[o] = D - 1;
    my_x_i = 2'(MY_X); my_y_i = 2'(MY_Y);
    reset_i = 1'b1; v_i = '1; data_i = '0; ready_and_i = '1;

    // T1: reset with every input valid
    d = {$urandom, $urandom};
    step("t1a", 1'b1, 5'b11111, d, 5'b11111);
    check("t1.v_o_zero", 64'(v_o), 64'd0);
    check("t1.yumi_zero", 64'(yumi_o), 64'd0);
    check("t1.data_zero", 64'(data_o), 64'd0);
    step("t1b", 1'b1, 5'b11111, d, 5'b11111);

    // T2: P to E
    pa = pk(4'hA, 3, 1);
    step("t2", 1'b0, 5'b00001, pack5(pa, 8'h0, 8'h0, 8'h0, 8'h0), 5'b00100);
    check("t2.v_e", 64'(v_o), 64'b00100);
    check("t2.data_e", 64'(data_o[2*W +: W]), 64'(pa));
    check("t2.yumi_p", 64'(yumi_o), 64'b00001);

    // T3: X-before-Y ordering
    step("t3a", 1'b0, 5'b00001, pack5(pk(4'h1, 0, 3), 0, 0, 0, 0), 5'b11111);
    check("t3a.to_w", 64'(v_o), 64'b00010);
    step("t3b", 1'b0, 5'b00001, pack5(pk(4'h2, 1, 0), 0, 0, 0, 0), 5'b11111);
    check("t3b.to_n", 64'(v_o), 64'b01000);
    step("t3c", 1'b0, 5'b00010, pack5(0, pk(4'h3, 1, 1), 0, 0, 0), 5'b11111);
    check("t3c.to_p", 64'(v_o), 64'b00001);
    check("t3c.yumi_w", 64'(yumi_o), 64'b00010);
    step("t3d", 1'b0, 5'b01000, pack5(0, 0, 0, pk(4'h4, 1, 3), 0), 5'b11111);
    check("t3d.to_s", 64'(v_o), 64'b10000);

    // T4: contention for E after a fresh reset
    step("t4rst", 1'b1, 5'b00000, '0, 5'b00000);
    for (int k = 0; k < 4; k++) begin
      pa = pk(4'(k), 3, 1);
      pb = pk(4'(k + 8), 3, 1);
      step("t4", 1'b0, 5'b00011, pack5(pa, pb, 0, 0, 0), 5'b00100);
      check("t4.alt", 64'(yumi_o), (k % 2 == 0) ? 64'b00001 : 64'b00010);
      check("t4.data", 64'(data_o[2*W +: W]), (k % 2 == 0) ? 64'(pa) : 64'(pb));
    end

    // T5: back-pressure on E
    pa = pk(4'h5, 3, 1);
    for (int k = 0; k < 3; k++) begin
      step("t5hold", 1'b0, 5'b00001, pack5(pa, 0, 0, 0, 0), 5'b00000);
      check("t5.v_e", 64'(v_o), 64'b00100);
      check("t5.no_yumi", 64'(yumi_o), 64'd0);
      check("t5.stable", 64'(data_o[2*W +: W]), 64'(pa));
    end
    step("t5go", 1'b0, 5'b00001, pack5(pa, 0, 0, 0, 0), 5'b00100);
    check("t5.yumi_p", 64'(yumi_o), 64'b00001);
    pb = pk(4'h6, 3, 1);
    step("t5adv", 1'b0, 5'b00011, pack5(pa, pb, 0, 0, 0), 5'b00100);
    check("t5.ptr_adv", 64'(yumi_o), 64'b00010);

    // T6: parallel transfers, then reset mid-stream
    d = pack5(pk(4'h7, 3, 1), pk(4'h8, 1, 1), 0, pk(4'h9, 1, 3), 0);
    step("t6par", 1'b0, 5'b01011, d, 5'b11111);
    check("t6.v_par", 64'(v_o), 64'b10101);
    check("t6.yumi_par", 64'(yumi_o), 64'b01011);
    step("t6rst", 1'b1, 5'b01011, d, 5'b11111);
    check("t6.rst_v", 64'(v_o), 64'd0);
    check("t6.rst_yumi", 64'(yumi_o), 64'd0);
    pa = pk(4'hB, 3, 1);
    pb = pk(4'hC, 3, 1);
    step("t6rel", 1'b0, 5'b00011, pack5(pa, pb, 0, 0, 0), 5'b00100);
    check("t6.restart_p", 64'(yumi_o), 64'b00001);

    // randomized traffic with occasional resets
    for (int k = 0; k < 400; k++) begin
      pc = 8'($urandom_range(0, 39));
      step("rnd", (pc == 8'd0), 5'($urandom), {$urandom, $urandom}, 5'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
